operand_scoreboard_fwd: RTL and testbench

- Parametrised operand-resolution unit for the decode stage.
- Generalises fixed EX/MEM/WB forwarding to N sources and N producer stages.
- Adds a tagged scoreboard for long-latency, out-of-order-completing ops (mul/div, miss loads).
- Emits resolved operands and one decode stall; scoreboard state is registered and survives across cycles.

---
 rtl/operand_scoreboard_fwd_pkg.sv | 23 ++
 rtl/operand_scoreboard_fwd_enc.sv | 26 ++
 rtl/operand_scoreboard_fwd.sv | 174 +++++++++++++++++
 tb/tb_operand_scoreboard_fwd.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_scoreboard_fwd_pkg.sv
// Shared types for the decode-stage operand resolution unit.
// scb_tag_t   : identifier handed to an outstanding long-latency op.
// fwd_src_e   : where a source operand was taken from (debug visibility).
// safeClog2   : index width that never collapses to zero bits.
package operand_scoreboard_fwd_pkg;

   localparam int SCB_NTAG = 4;
   localparam int SCB_TW   = $clog2(SCB_NTAG);

   typedef logic [SCB_TW-1:0] scb_tag_t;

   typedef enum logic [1:0] {
      FWD_ZERO,
      FWD_STAGE,
      FWD_LC,
      FWD_RF
   } fwd_src_e;

   function automatic int safeClog2(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/operand_scoreboard_fwd_enc.sv
// Lowest-free-tag priority encoder for the long-op scoreboard.
// busy_i      : one bit per tag, set while the tag is outstanding.
// alloc_tag_o : lowest index whose busy bit is clear (0 when none is free).
// tags_full_o : every tag is busy.
module lowest_free_enc #(
   parameter  int NTAG = 4,
   localparam int TW   = $clog2(NTAG)
) (
   input  logic [NTAG-1:0] busy_i,
   output logic [TW-1:0]   alloc_tag_o,
   output logic            tags_full_o
);

   // Scan from the top down so the lowest free index is the last one written.
   always_comb begin
      alloc_tag_o = '0;
      for (int t = NTAG - 1; t >= 0; t--) begin
         if (!busy_i[t]) begin
            alloc_tag_o = TW'(t);
         end
      end
   end

   assign tags_full_o = &busy_i;

endmodule

// File: rtl/operand_scoreboard_fwd.sv
// Decode-stage operand resolution with N-stage forwarding and a tagged
// scoreboard for long-latency ops that may complete out of order.
// clk_i/rst_ni           : clock, synchronous active-low reset.
// src_idx_i/rf_data_i    : source register indices and register-file data.
// dec_*_i, issue_fire_i  : the instruction in decode and whether it advances.
// fwd_*_i                : pipeline producer stages, index 0 youngest.
// lc_*_i                 : long-op completion (tag + result).
// opnd_data_o, stall_o   : resolved operands and decode hold.
// alloc_tag_o/tags_full_o: next tag for a long issue, and tag exhaustion.
// sb_err_o               : sticky protocol error.
module operand_scoreboard_fwd
   import operand_scoreboard_fwd_pkg::*;
#(
   parameter  int XLEN = 32,
   parameter  int NREG = 32,
   parameter  int NSRC = 2,
   parameter  int NFWD = 3,
   parameter  int NTAG = SCB_NTAG,
   localparam int RW   = $clog2(NREG),
   localparam int TW   = $clog2(NTAG),
   localparam int KW   = safeClog2(NFWD)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NSRC*RW-1:0]   src_idx_i,
   input  logic [NSRC*XLEN-1:0] rf_data_i,
   input  logic                 dec_valid_i,
   input  logic                 dec_wb_i,
   input  logic [RW-1:0]        dec_rd_i,
   input  logic                 dec_long_i,
   input  logic                 issue_fire_i,
   input  logic [NFWD-1:0]      fwd_valid_i,
   input  logic [NFWD*RW-1:0]   fwd_rd_i,
   input  logic [NFWD-1:0]      fwd_ok_i,
   input  logic [NFWD*XLEN-1:0] fwd_data_i,
   input  logic                 lc_valid_i,
   input  logic [TW-1:0]        lc_tag_i,
   input  logic [XLEN-1:0]      lc_data_i,
   output logic [NSRC*XLEN-1:0] opnd_data_o,
   output logic                 stall_o,
   output logic [TW-1:0]        alloc_tag_o,
   output logic                 tags_full_o,
   output logic                 sb_err_o
);

   logic [NREG-1:0] pend_q, pend_d;
   logic [TW-1:0]   ptag_q [NREG];
   logic [TW-1:0]   ptag_d [NREG];
   logic [NTAG-1:0] busy_q, busy_d;
   logic            sbErr_q, sbErr_d;
   logic [NSRC-1:0] rawVec;
   logic            waw;
   logic            longIssue;

   lowest_free_enc #(.NTAG(NTAG)) uEnc (
      .busy_i      (busy_q),
      .alloc_tag_o (alloc_tag_o),
      .tags_full_o (tags_full_o)
   );

   for (genvar s = 0; s < NSRC; s++) begin : gSrc
      logic [RW-1:0]   srcIdx;
      logic [KW-1:0]   hit;
      fwd_src_e        sel;
      logic            raw;
      logic [XLEN-1:0] opnd;

      // Pick the operand source. Stages are scanned oldest-first so the
      // youngest matching stage wins, and any pipeline writer shadows an
      // older pending long op. A pending register can still be read in
      // the cycle its completion arrives by bypassing lc_data.
      always_comb begin
         srcIdx = src_idx_i[s*RW +: RW];
         sel    = FWD_RF;
         hit    = '0;
         raw    = 1'b0;
         if (srcIdx == '0) begin
            sel = FWD_ZERO;
         end else begin
            for (int k = NFWD - 1; k >= 0; k--) begin
               if (fwd_valid_i[k] && (fwd_rd_i[k*RW +: RW] == srcIdx)) begin
                  sel = FWD_STAGE;
                  hit = KW'(k);
               end
            end
            if (sel == FWD_STAGE) begin
               raw = ~fwd_ok_i[hit];
            end else if (pend_q[srcIdx]) begin
               if (lc_valid_i && (ptag_q[srcIdx] == lc_tag_i)) begin
                  sel = FWD_LC;
               end else begin
                  raw = 1'b1;
               end
            end
         end
      end

      // Operand mux driven by the selected source.
      always_comb begin
         case (sel)
            FWD_ZERO:  opnd = '0;
            FWD_STAGE: opnd = fwd_data_i[hit*XLEN +: XLEN];
            FWD_LC:    opnd = lc_data_i;
            default:   opnd = rf_data_i[s*XLEN +: XLEN];
         endcase
      end

      assign opnd_data_o[s*XLEN +: XLEN] = opnd;
      assign rawVec[s] = raw;
   end

   // A decode writer must not overtake a pending long op to the same rd,
   // unless that op is completing right now.
   assign waw = dec_wb_i && (dec_rd_i != '0) && pend_q[dec_rd_i]
                && !(lc_valid_i && (ptag_q[dec_rd_i] == lc_tag_i));

   assign stall_o = dec_valid_i &&
                    ((|rawVec) || waw || (dec_long_i && dec_wb_i && tags_full_o));

   assign longIssue = issue_fire_i && dec_long_i && dec_wb_i && (dec_rd_i != '0);

   // Scoreboard next state. Completion is applied first and issue second so
   // that a set and a clear on the same register resolve to set. Completions
   // for idle tags are dropped and flagged; an issue with no free tag is
   // dropped and flagged rather than corrupting a live tag.
   always_comb begin
      pend_d  = pend_q;
      ptag_d  = ptag_q;
      busy_d  = busy_q;
      sbErr_d = sbErr_q;
      if (lc_valid_i) begin
         if (busy_q[lc_tag_i]) begin
            busy_d[lc_tag_i] = 1'b0;
            for (int r = 0; r < NREG; r++) begin
               if (pend_q[r] && (ptag_q[r] == lc_tag_i)) begin
                  pend_d[r] = 1'b0;
               end
            end
         end else begin
            sbErr_d = 1'b1;
         end
      end
      if (longIssue) begin
         if (tags_full_o) begin
            sbErr_d = 1'b1;
         end else begin
            pend_d[dec_rd_i]    = 1'b1;
            ptag_d[dec_rd_i]    = alloc_tag_o;
            busy_d[alloc_tag_o] = 1'b1;
         end
      end
   end

   // Pending/busy/error state with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pend_q  <= '0;
         busy_q  <= '0;
         sbErr_q <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         busy_q  <= busy_d;
         sbErr_q <= sbErr_d;
      end
   end

   // Tag table is only meaningful where pend is set, so it needs no reset.
   always_ff @(posedge clk_i) begin
      ptag_q <= ptag_d;
   end

   assign sb_err_o = sbErr_q;

endmodule

// File: tb/tb_operand_scoreboard_fwd.sv
// Scoreboard bench for operand_scoreboard_fwd: a driver applies directed and
// random decode cycles, predicts the outputs from a register/tag model and
// queues them; a monitor pops and compares on every valid decode cycle.
module tb_operand_scoreboard_fwd;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int NSRC = 2;
   localparam int NFWD = 3;
   localparam int NTAG = 4;
   localparam int RW   = 5;
   localparam int TW   = 2;

   logic                 clk;
   logic                 rstN;
   logic [NSRC*RW-1:0]   srcIdx;
   logic [NSRC*XLEN-1:0] rfData;
   logic                 decValid, decWb, decLong, issueFire;
   logic [RW-1:0]        decRd;
   logic [NFWD-1:0]      fwdValid, fwdOk;
   logic [NFWD*RW-1:0]   fwdRd;
   logic [NFWD*XLEN-1:0] fwdData;
   logic                 lcValid;
   logic [TW-1:0]        lcTag;
   logic [XLEN-1:0]      lcData;
   logic [NSRC*XLEN-1:0] opndData;
   logic                 stall, tagsFull, sbErr;
   logic [TW-1:0]        allocTag;

   typedef struct packed {
      logic [NSRC*XLEN-1:0] opnd;
      logic [NSRC-1:0]      known;
      logic                 stall;
      logic [TW-1:0]        allocTag;
      logic                 full;
      logic                 err;
      logic [31:0]          cyc;
   } exp_t;

   exp_t expQ[$];
   int   checks   = 0;
   int   failures = 0;
   int   cycleNo  = 0;

   int   pendTag [NREG];
   bit   tagBusy [NTAG];
   bit   errFlag;

   operand_scoreboard_fwd dut (
      .clk_i        (clk),
      .rst_ni       (rstN),
      .src_idx_i    (srcIdx),
      .rf_data_i    (rfData),
      .dec_valid_i  (decValid),
      .dec_wb_i     (decWb),
      .dec_rd_i     (decRd),
      .dec_long_i   (decLong),
      .issue_fire_i (issueFire),
      .fwd_valid_i  (fwdValid),
      .fwd_rd_i     (fwdRd),
      .fwd_ok_i     (fwdOk),
      .fwd_data_i   (fwdData),
      .lc_valid_i   (lcValid),
      .lc_tag_i     (lcTag),
      .lc_data_i    (lcData),
      .opnd_data_o  (opndData),
      .stall_o      (stall),
      .alloc_tag_o  (allocTag),
      .tags_full_o  (tagsFull),
      .sb_err_o     (sbErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model helpers.
   function automatic int lowestFree();
      for (int t = 0; t < NTAG; t++) if (!tagBusy[t]) return t;
      return 0;
   endfunction

   function automatic bit allBusy();
      for (int t = 0; t < NTAG; t++) if (!tagBusy[t]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic exp_t predict();
      exp_t e;
      int   idx, hit, rd;
      bit   raw, anyRaw, waw;
      e      = '0;
      anyRaw = 1'b0;
      for (int s = 0; s < NSRC; s++) begin
         idx = int'(srcIdx[s*RW +: RW]);
         raw = 1'b0;
         hit = -1;
         if (idx == 0) begin
            e.opnd[s*XLEN +: XLEN] = '0;
         end else begin
            for (int k = 0; k < NFWD; k++) begin
               if (hit < 0 && fwdValid[k] && int'(fwdRd[k*RW +: RW]) == idx) hit = k;
            end
            if (hit >= 0) begin
               if (fwdOk[hit]) e.opnd[s*XLEN +: XLEN] = fwdData[hit*XLEN +: XLEN];
               else raw = 1'b1;
            end else if (pendTag[idx] >= 0) begin
               if (lcValid && int'(lcTag) == pendTag[idx]) e.opnd[s*XLEN +: XLEN] = lcData;
               else raw = 1'b1;
            end else begin
               e.opnd[s*XLEN +: XLEN] = rfData[s*XLEN +: XLEN];
            end
         end
         e.known[s] = !raw;
         anyRaw     = anyRaw | raw;
      end
      rd  = int'(decRd);
      waw = decWb && rd != 0 && pendTag[rd] >= 0 && !(lcValid && int'(lcTag) == pendTag[rd]);
      e.full     = allBusy();
      e.allocTag = TW'(lowestFree());
      e.stall    = decValid && (anyRaw || waw || (decLong && decWb && e.full));
      e.err      = errFlag;
      e.cyc      = cycleNo;
      return e;
   endfunction

   task automatic updateModel();
      int  freeT;
      bit  wasFull;
      if (!rstN) begin
         for (int r = 0; r < NREG; r++) pendTag[r] = -1;
         for (int t = 0; t < NTAG; t++) tagBusy[t] = 1'b0;
         errFlag = 1'b0;
      end else begin
         freeT   = lowestFree();
         wasFull = allBusy();
         if (lcValid) begin
            if (tagBusy[lcTag]) begin
               tagBusy[lcTag] = 1'b0;
               for (int r = 0; r < NREG; r++) if (pendTag[r] == int'(lcTag)) pendTag[r] = -1;
            end else begin
               errFlag = 1'b1;
            end
         end
         if (issueFire && decLong && decWb && decRd != 0) begin
            if (wasFull) errFlag = 1'b1;
            else begin
               pendTag[decRd] = freeT;
               tagBusy[freeT] = 1'b1;
            end
         end
      end
   endtask

   // One decode cycle: predict, queue, clock, advance the model.
   task automatic applyStimulus(input bit ready);
      exp_t e;
      e = predict();
      issueFire = decValid && !e.stall && ready;
      if (decValid) expQ.push_back(e);
      @(posedge clk);
      updateModel();
      cycleNo++;
      #1;
   endtask

   task automatic compare(input string name, input logic [31:0] got, input logic [31:0] want,
                          input logic [31:0] cyc);
      checks++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, want);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      for (int s = 0; s < NSRC; s++) begin
         if (e.known[s]) compare($sformatf("opnd%0d", s), opndData[s*XLEN +: XLEN],
                                e.opnd[s*XLEN +: XLEN], e.cyc);
      end
      compare("stall", 32'(stall), 32'(e.stall), e.cyc);
      compare("alloc_tag", 32'(allocTag), 32'(e.allocTag), e.cyc);
      compare("tags_full", 32'(tagsFull), 32'(e.full), e.cyc);
      compare("sb_err", 32'(sbErr), 32'(e.err), e.cyc);
   endtask

   // Monitor: every valid decode cycle consumes exactly one expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rstN === 1'b1 && decValid === 1'b1) begin
            if (expQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL queue_underflow cyc=%0d got=empty exp=entry", cycleNo);
            end else begin
               e = expQ.pop_front();
               checkOutput(e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog cyc=%0d got=timeout exp=finish", cycleNo);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic setIdle();
      decValid = 1'b1; decWb = 1'b0; decLong = 1'b0; decRd = '0;
      fwdValid = '0; fwdRd = '0; fwdOk = '1;
      fwdData  = {$urandom, $urandom, $urandom};
      lcValid  = 1'b0; lcTag = '0; lcData = $urandom;
      srcIdx   = '0;
      rfData   = {$urandom, $urandom};
   endtask

   task automatic doReset(input int n);
      setIdle();
      decValid = 1'b0;
      rstN     = 1'b0;
      repeat (n) applyStimulus(1'b0);
      rstN = 1'b1;
   endtask

   task automatic longIssue(input int rd);
      setIdle();
      decLong = 1'b1; decWb = 1'b1; decRd = RW'(rd);
      applyStimulus(1'b1);
   endtask

   task automatic complete(input int tag);
      setIdle();
      lcValid = 1'b1; lcTag = TW'(tag);
      applyStimulus(1'b1);
   endtask

   initial begin
      int busyList[$];
      issueFire = 1'b0;
      errFlag   = 1'b0;
      for (int r = 0; r < NREG; r++) pendTag[r] = -1;
      for (int t = 0; t < NTAG; t++) tagBusy[t] = 1'b0;
      doReset(2);

      $display("[TB] reset state");
      setIdle();
      applyStimulus(1'b1);

      $display("[TB] stage forward");
      setIdle();
      fwdValid = 3'b011;
      fwdRd[0*RW +: RW] = 5'd5; fwdRd[1*RW +: RW] = 5'd5;
      fwdData[0*XLEN +: XLEN] = 32'hBBBB; fwdData[1*XLEN +: XLEN] = 32'hAAAA;
      srcIdx[0*RW +: RW] = 5'd5;
      applyStimulus(1'b1);

      $display("[TB] load-use");
      setIdle();
      fwdValid = 3'b001; fwdRd[0*RW +: RW] = 5'd7; fwdOk = 3'b110;
      srcIdx[1*RW +: RW] = 5'd7;
      applyStimulus(1'b1);
      fwdOk = 3'b111; fwdData[0*XLEN +: XLEN] = 32'h1234;
      applyStimulus(1'b1);

      $display("[TB] long op");
      longIssue(9);
      setIdle(); srcIdx[0*RW +: RW] = 5'd9;
      applyStimulus(1'b1);
      lcValid = 1'b1; lcTag = '0; lcData = 32'hDEAD;
      applyStimulus(1'b1);
      lcValid = 1'b0;
      applyStimulus(1'b1);

      $display("[TB] tag exhaustion");
      for (int r = 1; r <= 4; r++) longIssue(r);
      longIssue(5);
      complete(2);
      setIdle();
      applyStimulus(1'b1);
      complete(0); complete(1); complete(3);

      $display("[TB] waw and error");
      longIssue(9);
      setIdle(); decWb = 1'b1; decRd = 5'd9;
      applyStimulus(1'b1);
      complete(0);
      complete(1);
      setIdle(); repeat (3) applyStimulus(1'b1);
      doReset(1);
      setIdle(); applyStimulus(1'b1);
      longIssue(3);
      doReset(1);
      complete(0);
      setIdle(); applyStimulus(1'b1);
      doReset(1);

      $display("[TB] x0");
      setIdle();
      fwdValid = 3'b001; fwdRd[0*RW +: RW] = '0; fwdData[0*XLEN +: XLEN] = 32'hFFFF;
      applyStimulus(1'b1);
      longIssue(0);
      setIdle(); applyStimulus(1'b1);

      $display("[TB] random");
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 79) == 0) doReset(1);
         setIdle();
         decValid = ($urandom_range(0, 7) != 0);
         decWb    = $urandom_range(0, 1) == 1;
         decLong  = ($urandom_range(0, 2) == 0);
         decRd    = RW'($urandom_range(0, 7));
         for (int s = 0; s < NSRC; s++) srcIdx[s*RW +: RW] = RW'($urandom_range(0, 7));
         fwdValid = NFWD'($urandom);
         for (int k = 0; k < NFWD; k++) begin
            fwdRd[k*RW +: RW] = RW'($urandom_range(0, 7));
            fwdOk[k] = ($urandom_range(0, 4) != 0);
         end
         busyList.delete();
         for (int t = 0; t < NTAG; t++) if (tagBusy[t]) busyList.push_back(t);
         if (busyList.size() > 0 && $urandom_range(0, 99) < 35) begin
            lcValid = 1'b1;
            lcTag   = TW'(busyList[$urandom_range(0, busyList.size() - 1)]);
         end else if (busyList.size() < NTAG && $urandom_range(0, 149) == 0) begin
            lcValid = 1'b1;
            lcTag   = TW'(lowestFree());
         end
         applyStimulus($urandom_range(0, 3) != 0);
      end

      setIdle();
      decValid = 1'b0;
      applyStimulus(1'b0);
      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL queue_drain got=%0d exp=0", expQ.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
